mul_ctrl: RTL
=============

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  upstream operand pair valid.
REQ-004 in_ready  output  1  block can accept an operand pair.
REQ-005 in_multiplier  input  64  signed two's-complement multiplier operand.
REQ-006 in_multiplicand  input  64  signed two's-complement multiplicand operand.
REQ-007 out_valid  output  1  out_result holds a completed product.
REQ-008 out_ready  input  1  downstream accepts product.
REQ-009 out_result  output  128  signed product, registered.
REQ-010 mul_op_start / mul_op_clear  output  1 each  control to the radix-4 Booth multiplier.
REQ-011 mul_multiplier / mul_multiplicand  output  64 each  operands to the multiplier, driven from internal operand registers.
REQ-012 mul_op_done  input  1  multiplier completion flag.
REQ-013 mul_result  input  128  multiplier product.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  sticky timeout flag (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE, encoded in a 2-bit register.
REQ-017 IDLE: in_ready=1, mul_op_clear=1, mul_op_start=0; in_valid&&in_ready SHALL latch both operands and go to LOAD.
REQ-018 LOAD: exactly one cycle; mul_op_clear=1, mul_op_start=0, latched operands driven so the multiplier preloads its first Booth triplet; then go to RUN.
REQ-019 RUN: mul_op_clear=0, mul_op_start=1 every cycle; the first cycle mul_op_done=1 is sampled SHALL capture mul_result into out_result and go to DONE.
REQ-020 DONE: out_valid=1, mul_op_start=1, mul_op_clear=0; out_result and the operand registers SHALL stay stable; out_valid&&out_ready SHALL go to IDLE.
REQ-021 in_ready SHALL be 0 in LOAD, RUN and DONE; in_valid there SHALL be ignored with no operand overwrite.
REQ-022 mul_multiplier/mul_multiplicand SHALL change only on an accepted input in IDLE.
REQ-023 out_valid SHALL rise the cycle after mul_op_done is first sampled high; accept-to-out_valid latency with the team multiplier SHALL be 35 cycles.
REQ-024 A product SHALL be delivered exactly once per accepted operand pair; back-to-back transfers SHALL cost one IDLE cycle between pairs.
REQ-025 mul_op_done high in IDLE or LOAD SHALL be ignored.
REQ-026 out_result SHALL hold the last captured product until the next capture; it is not cleared on DONE->IDLE.

Reset
REQ-027 reset_n low SHALL immediately force state=IDLE, operand registers=0, out_result=0, out_valid=0, err=0, in_ready=1, mul_op_clear=1, mul_op_start=0, busy=0.
REQ-028 Reset mid-operation SHALL abandon the product with no out_valid pulse; the first accepted pair after release SHALL complete normally.

Configuration
REQ-029 Macro MUL_CTRL_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to RUN and increment each RUN cycle; on reaching 80 without mul_op_done, err SHALL set, the FSM SHALL return to IDLE with no out_valid, and err SHALL clear on the next accepted input.
REQ-030 Macro MUL_CTRL_TIMEOUT_EN undefined: no counter SHALL be built, err SHALL be tied 0, and RUN SHALL wait indefinitely.

Verification
REQ-031 Operands 3 and 5, out_ready=1 -> out_result=128'd15, out_valid one cycle, 35 cycles after accept.
REQ-032 Operands -1 and 2 -> out_result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE.
REQ-033 Operands 64'h7FFF_FFFF_FFFF_FFFF squared, out_ready held 0 for 10 cycles -> out_valid and 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001 stable; in_valid pulses ignored.
REQ-034 Two back-to-back pairs (2x7, 9x9) -> 14 then 81, in order, no loss.
REQ-035 reset_n low during cycle 10 of RUN -> all outputs at reset values; next pair 4x4 -> 16.
REQ-036 With MUL_CTRL_TIMEOUT_EN defined and mul_op_done forced 0 -> err=1 after 80 RUN cycles, FSM in IDLE, no out_valid; next accept clears err.

Source files
------------

// File: rtl/mul_ctrl.sv
// Sequencer between a valid/ready operand stream and a radix-4 Booth multiplier.
// Optional RUN timeout with sticky err: define MUL_CTRL_TIMEOUT_EN.
module mul_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_multiplier,
  input  logic [63:0]  in_multiplicand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_result,
  output logic         mul_op_start,
  output logic         mul_op_clear,
  output logic [63:0]  mul_multiplier,
  output logic [63:0]  mul_multiplicand,
  input  logic         mul_op_done,
  input  logic [127:0] mul_result,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   accept, capture;

`ifdef MUL_CTRL_TIMEOUT_EN
  localparam logic [7:0] RUN_LAST = 8'd79;
  logic [7:0] run_cnt;
  logic       timeout;
  logic       err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    mul_op_clear = 1'b0;
    mul_op_start = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
`ifdef MUL_CTRL_TIMEOUT_EN
    timeout      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        in_ready     = 1'b1;
        mul_op_clear = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        mul_op_clear = 1'b1;
        state_nx     = RUN;
      end
      RUN: begin
        mul_op_start = 1'b1;
        if (mul_op_done) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
`ifdef MUL_CTRL_TIMEOUT_EN
        // the 80th RUN cycle without done abandons the operation
        else if (run_cnt == RUN_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      DONE: begin
        out_valid    = 1'b1;
        mul_op_start = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // operands feed the multiplier directly and only move on an accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
    end else if (accept) begin
      mul_multiplier   <= in_multiplier;
      mul_multiplicand <= in_multiplicand;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     out_result <= '0;
    else if (capture) out_result <= mul_result;
  end

`ifdef MUL_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            run_cnt <= '0;
    else if (state == LOAD)  run_cnt <= '0;
    else if (state == RUN)   run_cnt <= run_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      err_q <= 1'b0;
    else if (accept)   err_q <= 1'b0;
    else if (timeout)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
